// File: rtl/converter_i2f_param.sv
// Parametrised integer/fixed-point to float converter with round-to-nearest-even,
// overflow saturation to Inf and flush-to-zero underflow, behind a STB/ACK handshake.
module converter_i2f_param #(
  parameter int IN_WIDTH  = 32,
  parameter int SIGNED    = 1,
  parameter int FRAC_BITS = 0,
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [IN_WIDTH-1:0]    i_A,
  input  logic                   i_A_STB,
  output logic                   o_A_ACK,
  output logic [EXP_W+MAN_W:0]   o_Z,
  output logic                   o_Z_STB,
  input  logic                   i_Z_ACK,
  output logic                   o_OVF,
  output logic                   o_UNF
);

  localparam int KW = $clog2(IN_WIDTH + 1);
  localparam int EW = ((EXP_W > 8) ? EXP_W : 8) + 2;
  localparam int XW = IN_WIDTH + MAN_W + 1;

  localparam logic signed [EW-1:0] E_TOP  = EW'(IN_WIDTH - 1 - FRAC_BITS);
  localparam logic signed [EW-1:0] BIAS_S = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t                   state, state_n;
  logic [IN_WIDTH-1:0]      a, a_n;
  logic [IN_WIDTH-1:0]      m, m_n;
  logic [KW-1:0]            k, k_n;
  logic signed [EW-1:0]     e, e_n;
  logic [MAN_W-1:0]         mant, mant_n;
  logic                     s, s_n;
  logic                     zero, zero_n;
  logic                     ack, ack_n;
  logic [EXP_W+MAN_W:0]     z, z_n;
  logic                     zstb, zstb_n;
  logic                     ovf, ovf_n;
  logic                     unf, unf_n;

  logic [IN_WIDTH-1:0]      a_neg;
  logic                     sign_bit;
  logic [XW-1:0]            ext;
  logic [MAN_W-1:0]         mant_f;
  logic [MAN_W-1:0]         mant_r;
  logic                     carry;
  logic                     guard;
  logic                     rnd;
  logic                     sticky;
  logic                     inc;
  logic signed [EW-1:0]     big_e;

  assign a_neg    = -a;
  assign sign_bit = (SIGNED != 0) ? a[IN_WIDTH-1] : 1'b0;

  // Bits below the hidden one, zero-padded so short inputs read missing bits as 0.
  assign ext    = {m[IN_WIDTH-2:0], {(MAN_W + 2){1'b0}}};
  assign mant_f = ext[XW-1 -: MAN_W];
  assign guard  = ext[XW-1-MAN_W];
  assign rnd    = ext[XW-2-MAN_W];
  assign sticky = |ext[XW-3-MAN_W:0];
  assign inc    = guard & (rnd | sticky | mant_f[0]);
  assign {carry, mant_r} = {1'b0, mant_f} + (MAN_W + 1)'(1);

  assign big_e = e + BIAS_S;

  always_comb begin
    state_n = state;
    a_n     = a;
    m_n     = m;
    k_n     = k;
    e_n     = e;
    mant_n  = mant;
    s_n     = s;
    zero_n  = zero;
    ack_n   = ack;
    z_n     = z;
    zstb_n  = zstb;
    ovf_n   = ovf;
    unf_n   = unf;
    case (state)
      GET_A: begin
        if (ack && i_A_STB) begin
          a_n     = i_A;
          ack_n   = 1'b0;
          state_n = CONVERT;
        end else begin
          ack_n = 1'b1;
        end
      end
      CONVERT: begin
        if (a == '0) begin
          s_n     = 1'b0;
          zero_n  = 1'b1;
          state_n = PACK;
        end else begin
          s_n     = sign_bit;
          m_n     = sign_bit ? a_neg : a;
          k_n     = '0;
          zero_n  = 1'b0;
          state_n = NORMALISE;
        end
      end
      NORMALISE: begin
        if (!m[IN_WIDTH-1]) begin
          m_n = m << 1;
          k_n = k + 1'b1;
        end else begin
          e_n     = E_TOP - signed'({{(EW - KW){1'b0}}, k});
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (inc && carry) begin
          mant_n = '0;
          e_n    = e + E_ONE;
        end else if (inc) begin
          mant_n = mant_r;
        end else begin
          mant_n = mant_f;
        end
        state_n = PACK;
      end
      PACK: begin
        // Biased exponent is evaluated signed and wide, so extreme shifts never wrap.
        if (zero) begin
          z_n   = '0;
          ovf_n = 1'b0;
          unf_n = 1'b0;
        end else if (big_e >= E_MAX) begin
          z_n   = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_n = 1'b1;
          unf_n = 1'b0;
        end else if (big_e <= E_ZERO) begin
          z_n   = {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          ovf_n = 1'b0;
          unf_n = 1'b1;
        end else begin
          z_n   = {s, big_e[EXP_W-1:0], mant};
          ovf_n = 1'b0;
          unf_n = 1'b0;
        end
        zstb_n  = 1'b1;
        state_n = PUT_Z;
      end
      PUT_Z: begin
        if (zstb && i_Z_ACK) begin
          zstb_n  = 1'b0;
          state_n = GET_A;
        end
      end
      default: begin
        state_n = GET_A;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= GET_A;
      a     <= '0;
      m     <= '0;
      k     <= '0;
      e     <= '0;
      mant  <= '0;
      s     <= 1'b0;
      zero  <= 1'b0;
      ack   <= 1'b0;
      z     <= '0;
      zstb  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      m     <= m_n;
      k     <= k_n;
      e     <= e_n;
      mant  <= mant_n;
      s     <= s_n;
      zero  <= zero_n;
      ack   <= ack_n;
      z     <= z_n;
      zstb  <= zstb_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  assign o_A_ACK = ack;
  assign o_Z     = z;
  assign o_Z_STB = zstb;
  assign o_OVF   = ovf;
  assign o_UNF   = unf;

endmodule
